// File: rtl/byte_striping_pkg.sv
// Shared types and constants for the two-lane byte striper.
package byte_striping_pkg;

    localparam int DATA_W_DEFAULT = 8;

    // K28.5 comma, used as the idle fill when the idle-fill build is selected.
    localparam logic [7:0] IDLE_SYMBOL = 8'hBC;
    localparam logic [7:0] ZERO_FILL   = 8'h00;

    // IDLE: nothing pending. HALF: lane 0 byte held in pend_q, waiting for lane 1.
    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_t;

endpackage

// File: rtl/byte_striping_lane_reg.sv
// One lane output register: load a launched word, clear to the fill value,
// or hold the current word.
module byte_striping_lane_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] fill,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    input  logic              vin,
    output logic [DATA_W-1:0] data_q,
    output logic              valid_q
);

    // Load has priority over clear; with neither, the lane word is held.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_q  <= fill;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= vin;
        end else if (clear) begin
            data_q  <= fill;
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_striping.sv
// Transmit-side byte striper: splits one byte stream at the clk_2f rate into
// two lanes, each word held for two clk_2f cycles (the clk_f rate).
// Lane 0 carries the even byte of a pair, lane 1 the odd byte.
//
// Handshake: valid-only, no ready. data_in is consumed on every edge where
// valid_in=1 and is ignored otherwise. valid_stripe_0/1 qualify the lane data;
// valid_stripe_1=1 implies valid_stripe_0=1.
//
// Build option: define BYTE_STRIPING_IDLE_FILL_EN to fill idle lanes (reset,
// idle, lane 1 of a partial pair) with 0xBC instead of 0x00.
module byte_striping
    import byte_striping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_stripe_0,
    output logic [DATA_W-1:0] data_stripe_1,
    output logic              valid_stripe_0,
    output logic              valid_stripe_1,
    output state_t            state_dbg
);

`ifdef BYTE_STRIPING_IDLE_FILL_EN
    localparam logic [DATA_W-1:0] FILL = DATA_W'(IDLE_SYMBOL);
`else
    localparam logic [DATA_W-1:0] FILL = DATA_W'(ZERO_FILL);
`endif

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] pend_q;
    logic              hold_q;

    logic              pend_load;
    logic              launch;
    logic              clear;
    logic [DATA_W-1:0] lane1_din;
    logic              lane1_vin;

    // Next state and lane controls: HALF always launches, IDLE clears the
    // lanes once the two-cycle hold of the previous launch has elapsed.
    always_comb begin
        state_d   = state_q;
        pend_load = 1'b0;
        launch    = 1'b0;
        clear     = 1'b0;
        lane1_din = FILL;
        lane1_vin = 1'b0;
        case (state_q)
            IDLE: begin
                clear = !hold_q;
                if (valid_in) begin
                    pend_load = 1'b1;
                    state_d   = HALF;
                end
            end
            HALF: begin
                launch  = 1'b1;
                state_d = IDLE;
                if (valid_in) begin
                    lane1_din = data_in;
                    lane1_vin = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending lane 0 byte and the one-cycle hold marker after a launch.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= launch;
            if (pend_load) begin
                pend_q <= data_in;
            end
        end
    end

    assign state_dbg = state_q;

    byte_striping_lane_reg #(.DATA_W(DATA_W)) u_lane_0 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .fill    (FILL),
        .load    (launch),
        .clear   (clear),
        .din     (pend_q),
        .vin     (1'b1),
        .data_q  (data_stripe_0),
        .valid_q (valid_stripe_0)
    );

    byte_striping_lane_reg #(.DATA_W(DATA_W)) u_lane_1 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .fill    (FILL),
        .load    (launch),
        .clear   (clear),
        .din     (lane1_din),
        .vin     (lane1_vin),
        .data_q  (data_stripe_1),
        .valid_q (valid_stripe_1)
    );

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping: directed steps plus a random loopback through a
// simple lane-merging receiver model.
module tb_byte_striping;
    import byte_striping_pkg::*;

    localparam int W  = 8;
    localparam int LW = 2 * W + 2;

`ifdef BYTE_STRIPING_IDLE_FILL_EN
    localparam logic [W-1:0] FILL = 8'hBC;
`else
    localparam logic [W-1:0] FILL = 8'h00;
`endif
    localparam logic [LW-1:0] IDLE_WORD = {1'b0, 1'b0, FILL, FILL};

    // clock / reset
    logic         clk_2f   = 1'b0;
    logic         reset    = 1'b1;
    logic         valid_in = 1'b0;
    logic [W-1:0] data_in  = '0;
    logic [W-1:0] data_stripe_0;
    logic [W-1:0] data_stripe_1;
    logic         valid_stripe_0;
    logic         valid_stripe_1;
    state_t       state_dbg;

    always #5 clk_2f = ~clk_2f;

    byte_striping #(.DATA_W(W)) dut (
        .clk_2f         (clk_2f),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .data_stripe_0  (data_stripe_0),
        .data_stripe_1  (data_stripe_1),
        .valid_stripe_0 (valid_stripe_0),
        .valid_stripe_1 (valid_stripe_1),
        .state_dbg      (state_dbg)
    );

    // scoreboard
    int              checks = 0;
    int              errors = 0;
    logic [LW-1:0]   exp_q[$];
    logic [W-1:0]    sent_q[$];
    logic [W-1:0]    rx_q[$];
    string           phase = "reset";

    // reference model state
    bit              have_pend = 1'b0;
    bit              hold_left = 1'b0;
    logic [W-1:0]    pend      = '0;
    logic [LW-1:0]   cur       = IDLE_WORD;
    bit              rx_skip   = 1'b0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] lanes();
        return {valid_stripe_0, valid_stripe_1, data_stripe_0, data_stripe_1};
    endfunction

    // driver: apply one cycle of input, predict, advance, compare, receive
    task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input bit record);
        reset    = rst;
        valid_in = v;
        data_in  = d;
        if (record && v && !rst) sent_q.push_back(d);
        if (rst) begin
            have_pend = 1'b0;
            hold_left = 1'b0;
            cur       = IDLE_WORD;
        end else if (have_pend) begin
            cur       = v ? {1'b1, 1'b1, pend, d} : {1'b1, 1'b0, pend, FILL};
            have_pend = 1'b0;
            hold_left = 1'b1;
        end else begin
            if (hold_left) hold_left = 1'b0;
            else           cur = IDLE_WORD;
            if (v) begin
                have_pend = 1'b1;
                pend      = d;
            end
        end
        exp_q.push_back(cur);
        @(posedge clk_2f);
        #1;
        check(phase, lanes(), exp_q.pop_front());
        if (rst) begin
            rx_skip = 1'b0;
        end else if (!rx_skip && valid_stripe_0) begin
            rx_q.push_back(data_stripe_0);
            if (valid_stripe_1) rx_q.push_back(data_stripe_1);
            rx_skip = 1'b1;
        end else begin
            rx_skip = 1'b0;
        end
    endtask

    task automatic expect_now(input string tag, input logic v0, input logic v1,
                              input logic [W-1:0] d0, input logic [W-1:0] d1);
        check(tag, lanes(), {v0, v1, d0, d1});
    endtask

    initial begin
        // reset held with a valid byte on the input
        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h55, 1'b0);
        expect_now("reset_lanes", 1'b0, 1'b0, FILL, FILL);
        check("reset_state", LW'(state_dbg), LW'(IDLE));
        step(1'b0, 1'b0, 8'h55, 1'b0);
        step(1'b0, 1'b0, 8'h55, 1'b0);
        expect_now("post_reset_idle", 1'b0, 1'b0, FILL, FILL);

        // continuous stream
        phase = "stream";
        step(1'b0, 1'b1, 8'h01, 1'b0);
        expect_now("one_byte_no_launch", 1'b0, 1'b0, FILL, FILL);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        expect_now("pair_01_02", 1'b1, 1'b1, 8'h01, 8'h02);
        step(1'b0, 1'b1, 8'h03, 1'b0);
        expect_now("pair_01_02_hold", 1'b1, 1'b1, 8'h01, 8'h02);
        step(1'b0, 1'b1, 8'h04, 1'b0);
        expect_now("pair_03_04", 1'b1, 1'b1, 8'h03, 8'h04);
        step(1'b0, 1'b0, 8'hEE, 1'b0);
        expect_now("pair_03_04_hold", 1'b1, 1'b1, 8'h03, 8'h04);
        step(1'b0, 1'b0, 8'hEE, 1'b0);
        expect_now("stream_idle", 1'b0, 1'b0, FILL, FILL);

        // odd burst
        phase = "odd_burst";
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        expect_now("pair_10_11", 1'b1, 1'b1, 8'h10, 8'h11);
        step(1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b0, 1'b0, 8'h5A, 1'b0);
        expect_now("partial_12", 1'b1, 1'b0, 8'h12, FILL);
        step(1'b0, 1'b0, 8'h5A, 1'b0);
        expect_now("partial_12_hold", 1'b1, 1'b0, 8'h12, FILL);
        step(1'b0, 1'b0, 8'h5A, 1'b0);
        expect_now("odd_idle", 1'b0, 1'b0, FILL, FILL);

        // gapped input
        phase = "gapped";
        step(1'b0, 1'b1, 8'hA0, 1'b0);
        step(1'b0, 1'b0, 8'hFF, 1'b0);
        expect_now("partial_a0", 1'b1, 1'b0, 8'hA0, FILL);
        step(1'b0, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b1, 8'hA2, 1'b0);
        expect_now("pair_a1_a2", 1'b1, 1'b1, 8'hA1, 8'hA2);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // reset mid-pair
        phase = "reset_mid_pair";
        step(1'b0, 1'b1, 8'h77, 1'b0);
        check("half_state", LW'(state_dbg), LW'(HALF));
        step(1'b1, 1'b0, 8'h00, 1'b0);
        expect_now("mid_reset_lanes", 1'b0, 1'b0, FILL, FILL);
        check("mid_reset_state", LW'(state_dbg), LW'(IDLE));
        step(1'b0, 1'b1, 8'h88, 1'b0);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        expect_now("pair_88_99", 1'b1, 1'b1, 8'h88, 8'h99);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // random loopback through the receiver model
        phase = "loopback";
        rx_q.delete();
        sent_q.delete();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, W'($urandom_range(0, 255)), 1'b1);
            step(1'b0, 1'b1, W'($urandom_range(0, 255)), 1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("loopback_count", LW'(rx_q.size()), LW'(sent_q.size()));
        for (int i = 0; i < sent_q.size(); i++) begin
            if (i < rx_q.size()) check("loopback_byte", LW'(rx_q[i]), LW'(sent_q[i]));
        end

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
